// File: rtl/pc_pkg.sv
// pc_pkg: shared constants for the fetch PC / branch predictor block.
//   - 2-bit saturating counter encodings and the reset/allocate values
//   - default reset PC and sequential fetch increment
//   - helper to turn a counter value into a taken/not-taken prediction
package pc_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_INST_BYTES = 4;

  // The counter MSB alone decides the predicted direction.
  function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/pc_predict_unit_sat_counter2.sv
// sat_counter2: pure combinational 2-bit saturating counter step.
// Ports:
//   ctr_i  - current counter value
//   inc_i  - 1: count up (saturate at CTR_ST), 0: count down (saturate at CTR_SNT)
//   ctr_o  - next counter value
module sat_counter2
  import pc_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: IF-stage fetch PC register with a direct-mapped BTB.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   stall                   - hold the fetch PC
//   redirect_valid/_pc      - EX misprediction redirect (beats stall)
//   update_valid/_pc/_taken/_target - EX training of the BTB
//   current_pc              - registered fetch PC
//   pred_taken/pred_target  - combinational prediction for current_pc
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int              BTB_ENTRIES = 16,
  parameter int              INST_BYTES  = DEFAULT_INST_BYTES
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  output logic [XLEN-1:0] current_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // BTB storage kept as flop arrays so the whole table clears asynchronously.
  logic              valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]   target_q [BTB_ENTRIES];
  logic [1:0]        ctr_q    [BTB_ENTRIES];

  logic [XLEN-1:0]   current_pc_q, current_pc_d;

  // Lookup on the registered fetch PC (pre-edge table contents).
  logic [IDX_W-1:0]  lkp_idx;
  logic [TAG_W-1:0]  lkp_tag;
  logic              lkp_hit;
  logic [XLEN-1:0]   seq_pc;

  assign lkp_idx = current_pc_q[IDX_W+1:2];
  assign lkp_tag = current_pc_q[XLEN-1:IDX_W+2];
  assign lkp_hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign seq_pc  = current_pc_q + XLEN'(INST_BYTES);  // wraps modulo 2^XLEN

  assign pred_taken  = lkp_hit && ctr_predicts_taken(ctr_q[lkp_idx]);
  assign pred_target = pred_taken ? target_q[lkp_idx] : seq_pc;
  assign current_pc  = current_pc_q;

  always_comb begin
    current_pc_d = pred_target;
    if (redirect_valid)  current_pc_d = redirect_pc;
    else if (stall)      current_pc_d = current_pc_q;
  end

  // Training path.
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic [1:0]        upd_ctr_step;
  logic              upd_wr_en;
  logic [1:0]        upd_ctr_d;
  logic [XLEN-1:0]   upd_target_d;

  // Byte-offset bits never participate in indexing or tagging.
  logic [1:0]        unused_upd_lsb;
  assign unused_upd_lsb = update_pc[1:0];

  assign upd_idx = update_pc[IDX_W+1:2];
  assign upd_tag = update_pc[XLEN-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter2 u_sat_counter2 (
    .ctr_i (ctr_q[upd_idx]),
    .inc_i (update_taken),
    .ctr_o (upd_ctr_step)
  );

  always_comb begin
    // A miss that resolved not-taken leaves the table untouched; a taken miss
    // evicts whatever lives at that index.
    upd_wr_en    = update_valid && (upd_hit || update_taken);
    upd_ctr_d    = upd_hit ? upd_ctr_step : CTR_ALLOC;
    upd_target_d = update_taken ? update_target : target_q[upd_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      current_pc_q <= RESET_PC;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      current_pc_q <= current_pc_d;
      if (upd_wr_en) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_d;
        ctr_q[upd_idx]    <= upd_ctr_d;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: directed, table-driven bench for pc_predict_unit.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [31:0] current_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_predict_unit #(
    .XLEN(32), .RESET_PC(32'h0), .BTB_ENTRIES(16), .INST_BYTES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .current_pc(current_pc), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        exp_pt;    // pred_taken before the edge
    logic [31:0] exp_ptgt;  // pred_target before the edge
    logic [31:0] exp_pc;    // current_pc after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic rv, input logic [31:0] rpc,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic pt,
                     input logic [31:0] ptgt, input logic [31:0] pc);
    vec_t v;
    v.stall = s; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc;
    v.ut = ut; v.utgt = utgt; v.exp_pt = pt; v.exp_ptgt = ptgt; v.exp_pc = pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt);
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    update_valid = uv; update_pc = upc; update_taken = ut; update_target = utgt;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: sequential fetch
    add(0,0,32'h0,   0,32'h0,0,32'h0,     0,32'h4,  32'h4);
    add(0,0,32'h0,   0,32'h0,0,32'h0,     0,32'h8,  32'h8);
    add(0,0,32'h0,   0,32'h0,0,32'h0,     0,32'hC,  32'hC);
    add(0,0,32'h0,   0,32'h0,0,32'h0,     0,32'h10, 32'h10);
    // 2: stall hold, redirect beats stall
    add(0,1,32'h20,  0,32'h0,0,32'h0,     0,32'h14, 32'h20);
    add(1,0,32'h0,   0,32'h0,0,32'h0,     0,32'h24, 32'h20);
    add(1,0,32'h0,   0,32'h0,0,32'h0,     0,32'h24, 32'h20);
    add(1,0,32'h0,   0,32'h0,0,32'h0,     0,32'h24, 32'h20);
    add(1,1,32'h100, 0,32'h0,0,32'h0,     0,32'h24, 32'h100);
    // 3: allocate 0x40 -> 0x200, then predicted taken
    add(0,1,32'h40,  1,32'h40,1,32'h200,  0,32'h104,32'h40);
    add(0,0,32'h0,   0,32'h0,0,32'h0,     1,32'h200,32'h200);
    // 4: saturate up (10->11), then walk down to 00
    add(0,0,32'h0,   1,32'h40,1,32'h200,  0,32'h204,32'h204);
    add(0,0,32'h0,   1,32'h40,1,32'h200,  0,32'h208,32'h208);
    add(0,0,32'h0,   1,32'h40,1,32'h200,  0,32'h20C,32'h20C);
    add(0,1,32'h40,  1,32'h40,0,32'h0,    0,32'h210,32'h40);   // 11->10
    add(0,0,32'h0,   0,32'h0,0,32'h0,     1,32'h200,32'h200);  // still taken
    add(0,0,32'h0,   1,32'h40,0,32'h0,    0,32'h204,32'h204);  // 10->01
    add(0,1,32'h40,  1,32'h40,0,32'h0,    0,32'h208,32'h40);   // 01->00
    add(0,0,32'h0,   0,32'h0,0,32'h0,     0,32'h44, 32'h44);
    add(0,1,32'h40,  1,32'h40,0,32'h0,    0,32'h48, 32'h40);   // 00 stays 00
    add(0,0,32'h0,   1,32'h40,1,32'h200,  0,32'h44, 32'h44);   // 00->01
    add(0,1,32'h40,  0,32'h0,0,32'h0,     0,32'h48, 32'h40);
    add(0,0,32'h0,   0,32'h0,0,32'h0,     0,32'h44, 32'h44);   // 01 not taken
    // 5: aliasing 0x40 vs 0x440 on index 0
    add(0,0,32'h0,   1,32'h40,1,32'h200,  0,32'h48, 32'h48);   // 01->10
    add(0,1,32'h40,  1,32'h440,1,32'h300, 0,32'h4C, 32'h40);   // evict
    add(0,1,32'h440, 0,32'h0,0,32'h0,     0,32'h44, 32'h440);  // 0x40 misses
    add(0,0,32'h0,   0,32'h0,0,32'h0,     1,32'h300,32'h300);

    reset_n = 1'b0;
    idle();
    step();
    step();
    chk("reset_pc", current_pc, 32'h0);
    chk("reset_pred_taken", 32'(pred_taken), 32'h0);
    chk("reset_pred_target", pred_target, 32'h4);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].uv,
            vecs[i].upc, vecs[i].ut, vecs[i].utgt);
      chk($sformatf("v%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].exp_pt));
      chk($sformatf("v%0d_pred_target", i), pred_target, vecs[i].exp_ptgt);
      step();
      chk($sformatf("v%0d_pc", i), current_pc, vecs[i].exp_pc);
      $display("vec %0d: pc=%h pred_taken=%0d pred_target=%h",
               i, current_pc, pred_taken, pred_target);
    end

    // Wrap-around at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
    step();
    idle();
    chk("wrap_pc_at_top", current_pc, 32'hFFFF_FFFC);
    chk("wrap_pred_taken", 32'(pred_taken), 32'h0);
    chk("wrap_pred_target", pred_target, 32'h0);
    step();
    chk("wrap_pc", current_pc, 32'h0);
    $display("seq wrap: pc=%h", current_pc);

    // Same-cycle update and lookup of the fetched PC uses the old entry.
    drive(0, 1, 32'h80, 0, 32'h0, 0, 32'h0);
    step();
    drive(0, 0, 32'h0, 1, 32'h80, 1, 32'h500);
    chk("same_cycle_pred_taken", 32'(pred_taken), 32'h0);
    chk("same_cycle_pred_target", pred_target, 32'h84);
    step();
    chk("same_cycle_pc", current_pc, 32'h84);
    drive(0, 1, 32'h80, 0, 32'h0, 0, 32'h0);
    step();
    idle();
    chk("after_update_pred_taken", 32'(pred_taken), 32'h1);
    chk("after_update_pred_target", pred_target, 32'h500);
    step();
    chk("after_update_pc", current_pc, 32'h500);
    $display("seq same-cycle: pc=%h", current_pc);

    // Asynchronous reset mid-stream clears PC and table without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_pc", current_pc, 32'h0);
    chk("async_reset_pred_target", pred_target, 32'h4);
    step();
    reset_n = 1'b1;
    step();
    chk("post_reset_pc", current_pc, 32'h4);
    drive(0, 1, 32'h80, 0, 32'h0, 0, 32'h0);
    step();
    idle();
    chk("post_reset_entry_invalid", 32'(pred_taken), 32'h0);
    chk("post_reset_seq_target", pred_target, 32'h84);
    drive(0, 1, 32'h440, 0, 32'h0, 0, 32'h0);
    step();
    idle();
    chk("post_reset_alias_invalid", 32'(pred_taken), 32'h0);
    $display("seq reset: pc=%h pred_taken=%0d", current_pc, pred_taken);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Parametrised next-generation program-counter block for the pipelined core's IF stage. It holds the architectural fetch PC and supports stall-hold and EX-stage redirect. It also adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch follows predicted-taken branches without waiting for EX resolution. Trained by EX each cycle a control instruction resolves.

Parameters:
XLEN, 32, PC/target width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2
INST_BYTES, 4, sequential fetch increment in bytes

Ports:
clk  in  1  core clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
stall  in  1  hazard stall from hazard unit; hold PC
redirect_valid  in  1  EX detected misprediction; load redirect_pc
redirect_pc  in  XLEN  correct next PC from EX
update_valid  in  1  EX resolved a control instruction this cycle
update_pc  in  XLEN  PC of the resolved instruction
update_taken  in  1  actual direction of the resolved instruction
update_target  in  XLEN  actual target of the resolved instruction
current_pc  out  XLEN  registered fetch PC
pred_taken  out  1  combinational: BTB predicts current_pc taken
pred_target  out  XLEN  combinational: predicted next PC (target or current_pc+INST_BYTES)

Behaviour:
- IDX_W = log2(BTB_ENTRIES); index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Entry fields: valid, tag, target[XLEN], ctr[2].
- Reset (reset_n=0, async, takes effect immediately):
  - current_pc = RESET_PC
  - all valid = 0; all ctr = 2'b01; tag/target = 0
  - pred_taken therefore 0; pred_target = RESET_PC + INST_BYTES
- Lookup (combinational on current_pc): hit = valid[index] && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? target : current_pc + INST_BYTES.
- Next-PC priority at each rising edge:
  1. redirect_valid -> redirect_pc; overrides stall.
  2. stall -> hold current_pc.
  3. else -> pred_target.
- Latency: redirect_pc or pred_target is visible on current_pc one cycle after the sampling edge. No bubble for correctly predicted taken branches.
- Sequential add is modulo 2^XLEN; 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
- Training (update_valid=1, at the edge), applied to the entry at index(update_pc):
  - Hit, taken: ctr saturating +1 (max 2'b11); target = update_target.
  - Hit, not taken: ctr saturating -1 (min 2'b00); target unchanged.
  - Miss, taken: allocate; valid=1, tag = tag(update_pc), target = update_target, ctr=2'b10. Replaces any occupant.
  - Miss, not taken: no change.
- Training proceeds regardless of stall or redirect.
- Same-cycle lookup and update of the same index: lookup uses pre-edge contents. No write-through bypass.
- Reset asserted mid-operation: PC and table are cleared immediately. Fetch resumes from RESET_PC on the first edge after reset_n rises.
- update_pc/redirect_pc low 2 bits are ignored for indexing. No misalignment checking.

Decomposition:
- Shared package pc_pkg:
  - counter encodings: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11
  - CTR_RESET = CTR_WNT; CTR_ALLOC = CTR_WT
  - default RESET_PC and INST_BYTES constants
- One sub-module: sat_counter2, a pure combinational 2-bit saturating inc/dec.
- BTB storage stays as register arrays inside pc_predict_unit, to keep the async clear.

Test Plan:
1. Reset and sequential fetch: RESET_PC=0; release reset_n, 4 edges -> current_pc 0,4,8,12,16; pred_taken=0 throughout.
2. Stall vs redirect: at PC=0x20, stall=1 for 3 cycles -> PC holds 0x20. Then stall=1 with redirect_valid=1, redirect_pc=0x100 -> next PC=0x100.
3. Allocate and predict:
   - update_valid, update_pc=0x40, taken, target=0x200 -> entry valid, ctr=10.
   - When current_pc reaches 0x40 -> pred_taken=1, next PC=0x200.
4. Counter saturation and hysteresis, trained on 0x40:
   - taken x3 -> ctr=11.
   - not-taken x1 -> ctr=10, still predicts 0x200.
   - not-taken x2 more -> ctr=00; at 0x40, next PC=0x44.
5. Aliasing, BTB_ENTRIES=16: train 0x40 taken ->0x200, then 0x440 taken ->0x300.
   - Fetch at 0x40 -> tag miss, pred_taken=0.
   - Fetch at 0x440 -> 0x300.
6. Edge cases:
   - PC=0xFFFF_FFFC, no hit -> wraps to 0.
   - Same-cycle update and lookup of the fetched PC -> prediction uses old entry; new entry takes effect the next cycle.
   - reset_n pulsed mid-stream -> current_pc=0 immediately, all entries invalid.
